core_fetch: RTL and testbench

- Instruction-fetch stage of the LETC core: the producing end of the fetch-to-decode interface.
- Holds the PC and issues in-order word reads to the instruction memory port.
- Buffers returned instructions, tagged with their PC, and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from later stages and squashes all stale fetches.

---
 rtl/core_pkg.sv | 16 +
 rtl/core_fetch_buffer.sv | 63 ++++++
 rtl/core_fetch.sv | 133 +++++++++++++
 tb/tb_core_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// LETC core shared package.
// Inter-stage bundles and reset constants.
package core_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  fault;
  } fetch_to_decode_s;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/core_fetch_buffer.sv
// Small synchronous FIFO with flush, used for the
// fetch instruction buffer and the PC tag queue.
module core_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // a full buffer may still take a push when the head leaves
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/core_fetch.sv
// LETC instruction fetch stage: PC, credit-limited
// memory requests, tagged buffer and redirect squash.
module core_fetch
  import core_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_to_d_valid,
  input  logic        f_to_d_ready,
  output logic [31:0] f_to_d_instr,
  output logic [31:0] f_to_d_pc,
  output logic        f_to_d_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t            pc_q;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    discard_q;
  logic [CW-1:0]    buf_count;
  logic [CW-1:0]    tag_count;
  logic             buf_full;
  logic             buf_empty;
  logic             tag_full;
  logic             tag_empty;
  logic             req_fire;
  logic             rsp_keep;
  logic             pop;
  word_t            tag_pc;
  fetch_to_decode_s buf_in;
  fetch_to_decode_s buf_out;

  // discarded responses still hold credit until they return
  assign imem_req_valid = rst_n && !redirect_valid &&
    (({1'b0, inflight_q} + {1'b0, buf_count}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q & WORD_ALIGN_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (discard_q == '0) &&
                          !redirect_valid;
  assign pop            = f_to_d_valid && f_to_d_ready;

  assign buf_in = '{instr: imem_rsp_data,
                    pc:    tag_pc,
                    fault: imem_rsp_fault};

  assign f_to_d_valid = !buf_empty;
  assign f_to_d_instr = buf_out.instr;
  assign f_to_d_pc    = buf_out.pc;
  assign f_to_d_fault = buf_out.fault;

  core_fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (req_fire),
    .wdata (imem_req_addr),
    .pop   (rsp_keep),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  core_fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_to_decode_s))
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (rsp_keep),
    .wdata (buf_in),
    .pop   (pop),
    .rdata (buf_out),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & WORD_ALIGN_MASK;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc_q      <= redirect_pc & WORD_ALIGN_MASK;
        // everything still unanswered after this cycle is stale
        discard_q <= inflight_q - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (imem_rsp_valid && (discard_q != '0))
          discard_q <= discard_q - CW'(1);
      end
    end
  end

  a_rsp_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (inflight_q == '0)));

  a_tag_present: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(rsp_keep && tag_empty));

  a_tag_room: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(req_fire && tag_full));

  a_buf_room: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(rsp_keep && buf_full && !pop));

  a_tag_le_inflight: assert property (
    @(posedge clk) disable iff (!rst_n)
    tag_count <= inflight_q);

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch with an in-order
// 1-cycle instruction memory model.
module tb_core_fetch;
  import core_pkg::*;

  localparam word_t FAULT_ADDR = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_to_d_valid;
  logic        f_to_d_ready;
  logic [31:0] f_to_d_instr;
  logic [31:0] f_to_d_pc;
  logic        f_to_d_fault;

  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_rsp_fault;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_fault;

  int total  = 0;
  int passed = 0;
  logic rsp_en;
  word_t pend[$];
  fetch_to_decode_s hlog[$];
  word_t cap_pc;
  word_t last_pc;
  word_t a_addr;

  always #5 clk = ~clk;

  core_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_fault (imem_rsp_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_to_d_valid   (f_to_d_valid),
    .f_to_d_ready   (f_to_d_ready),
    .f_to_d_instr   (f_to_d_instr),
    .f_to_d_pc      (f_to_d_pc),
    .f_to_d_fault   (f_to_d_fault)
  );

  core_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_hi (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .imem_rsp_fault (w_rsp_fault),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .f_to_d_valid   (w_valid),
    .f_to_d_ready   (w_ready),
    .f_to_d_instr   (w_instr),
    .f_to_d_pc      (w_pc),
    .f_to_d_fault   (w_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic word_t log_pc(input int k);
    return (hlog.size() > k) ? hlog[k].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic word_t log_instr(input int k);
    return (hlog.size() > k) ? hlog[k].instr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic log_fault(input int k);
    return (hlog.size() > k) ? hlog[k].fault : 1'bx;
  endfunction

  // sample at negedge, advance one edge, drive memory at +1
  task automatic tick();
    logic  fire;
    word_t a;
    @(negedge clk);
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    if (f_to_d_valid && f_to_d_ready)
      hlog.push_back('{instr: f_to_d_instr, pc: f_to_d_pc,
                       fault: f_to_d_fault});
    @(posedge clk);
    #1;
    if (fire) pend.push_back(a);
    if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~a;
      imem_rsp_fault = (a == FAULT_ADDR);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_fault = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    imem_rsp_fault = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    f_to_d_ready = 1'b1;
    w_req_ready = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data = '0;
    w_rsp_fault = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = '0;
    w_ready = 1'b0;
    rsp_en = 1'b1;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_d_valid", 32'(f_to_d_valid), 32'd0);
    chk("rst_d_instr", f_to_d_instr, 32'h0);
    chk("rst_d_pc", f_to_d_pc, 32'h0);
    chk("rst_d_fault", 32'(f_to_d_fault), 32'd0);
    chk("rst_hi_addr", w_req_addr, 32'hFFFF_FFF8);
    chk("rst_hi_valid", 32'(w_req_valid), 32'd0);

    rst_n = 1'b1;
    #2;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    chk("hi_addr0", w_req_addr, 32'hFFFF_FFF8);

    tick();
    #2;
    chk("lat_not_yet", 32'(f_to_d_valid), 32'd0);
    chk("hi_addr1", w_req_addr, 32'hFFFF_FFFC);
    chk("hi_valid1", 32'(w_req_valid), 32'd1);
    tick();
    #2;
    chk("lat_valid", 32'(f_to_d_valid), 32'd1);
    chk("lat_pc", f_to_d_pc, 32'h0);
    chk("lat_instr", f_to_d_instr, 32'hFFFF_FFFF);
    chk("hi_addr_wrap", w_req_addr, 32'h0000_0000);
    chk("hi_no_credit", 32'(w_req_valid), 32'd0);

    ticks(12);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("seq_pc%0d", k), log_pc(k), 32'(4 * k));
      chk($sformatf("seq_instr%0d", k), log_instr(k), ~32'(4 * k));
      chk($sformatf("seq_fault%0d", k), 32'(log_fault(k)),
          32'(k == 2));
    end

    last_pc = log_pc(hlog.size() - 1);
    hlog.delete();
    f_to_d_ready = 1'b0;
    ticks(4);
    #2;
    cap_pc = last_pc + 32'd4;
    chk("stall_pend", 32'(pend.size()), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("stall_valid", 32'(f_to_d_valid), 32'd1);
      chk("stall_pc", f_to_d_pc, cap_pc);
      chk("stall_instr", f_to_d_instr, ~cap_pc);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      #2;
    end
    f_to_d_ready = 1'b1;
    ticks(6);
    chk("resume_pc0", log_pc(0), cap_pc);
    chk("resume_pc1", log_pc(1), cap_pc + 32'd4);

    rsp_en = 1'b0;
    ticks(6);
    chk("rd1_pend", 32'(pend.size()), 32'd2);
    chk("rd1_no_req", 32'(imem_req_valid), 32'd0);
    hlog.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    #2;
    chk("rd1_gate", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_pc = 32'h0000_1002;
    #2;
    chk("rd1_gate2", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("rd1_addr", imem_req_addr, 32'h0000_1000);
    chk("rd1_wait_stale", 32'(imem_req_valid), 32'd0);
    chk("rd1_d_valid", 32'(f_to_d_valid), 32'd0);
    rsp_en = 1'b1;
    ticks(10);
    chk("rd1_pc0", log_pc(0), 32'h0000_1000);
    chk("rd1_instr0", log_instr(0), ~32'h0000_1000);
    chk("rd1_pc1", log_pc(1), 32'h0000_1004);

    rsp_en = 1'b0;
    ticks(6);
    chk("rd2_pend", 32'(pend.size()), 32'd2);
    a_addr = pend[0];
    f_to_d_ready = 1'b0;
    rsp_en = 1'b1;
    tick();
    rsp_en = 1'b0;
    tick();
    #2;
    chk("rd2_buffered", 32'(f_to_d_valid), 32'd1);
    chk("rd2_head", f_to_d_pc, a_addr);
    chk("rd2_no_req", 32'(imem_req_valid), 32'd0);
    hlog.delete();
    rsp_en = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3001;
    f_to_d_ready = 1'b1;
    #2;
    chk("rd2_pop_valid", 32'(f_to_d_valid), 32'd1);
    chk("rd2_gate", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("rd2_flushed", 32'(f_to_d_valid), 32'd0);
    chk("rd2_addr", imem_req_addr, 32'h0000_3000);
    chk("rd2_req_now", 32'(imem_req_valid), 32'd1);
    ticks(8);
    chk("rd2_handoff", log_pc(0), a_addr);
    chk("rd2_pc0", log_pc(1), 32'h0000_3000);
    chk("rd2_pc1", log_pc(2), 32'h0000_3004);
    chk("rd2_fault", 32'(log_fault(1)), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
